// File: rtl/run_controller.sv
// Run controller: sequences a bounded processor run through IDLE -> RUN -> DRAIN -> DONE.
// A run ends on a processor halt, a stalled program counter, or the cycle budget,
// and the cause is latched in halted/timeout.
module run_controller #(
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned RUNTIME    = 100,
  parameter int unsigned DRAIN      = 1,
  parameter int unsigned PC_W       = 32,
  parameter int unsigned IDLE_LIMIT = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             halt_req,
  input  logic [PC_W-1:0]  pc,
  input  logic             pc_valid,
  output logic             complete,
  output logic             finish,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] cycles,
  output logic             timeout,
  output logic             halted
);

  localparam int unsigned STALL_W = 32;
  localparam int unsigned DRAIN_W = 8;

  // RUN ends once the budget minus the drain window has been spent.
  localparam logic [CNT_W-1:0]   BUDGET      = CNT_W'(RUNTIME - DRAIN);
  localparam logic [STALL_W-1:0] STALL_LIMIT = STALL_W'(IDLE_LIMIT);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST  = DRAIN_W'(DRAIN - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cycles_q, cycles_d;
  logic               timeout_q, timeout_d;
  logic               halted_q, halted_d;
  logic               complete_q, complete_d;
  logic               finish_q, finish_d;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic [PC_W-1:0]    last_pc_q, last_pc_d;
  logic               have_pc_q, have_pc_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;

  logic [CNT_W-1:0]   cycles_inc;
  logic               stall_hit;
  logic               budget_hit;

  // Next-state, counters and exit-cause selection.
  always_comb begin
    state_d    = state_q;
    cycles_d   = cycles_q;
    timeout_d  = timeout_q;
    halted_d   = halted_q;
    stall_d    = stall_q;
    last_pc_d  = last_pc_q;
    have_pc_d  = have_pc_q;
    drain_d    = drain_q;
    cycles_inc = (cycles_q == '1) ? cycles_q : cycles_q + CNT_W'(1);
    stall_hit  = 1'b0;
    budget_hit = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d   = S_RUN;
          cycles_d  = '0;
          timeout_d = 1'b0;
          halted_d  = 1'b0;
          stall_d   = '0;
          have_pc_d = 1'b0;
        end
      end
      S_RUN: begin
        cycles_d = cycles_inc;
        // The first valid pc of a run only establishes the reference value.
        if (pc_valid) begin
          if (have_pc_q && (pc == last_pc_q)) begin
            stall_d = (stall_q == '1) ? stall_q : stall_q + STALL_W'(1);
          end else begin
            stall_d = '0;
          end
          last_pc_d = pc;
          have_pc_d = 1'b1;
        end
        stall_hit  = (IDLE_LIMIT != 0) && (stall_d == STALL_LIMIT);
        budget_hit = (cycles_inc >= BUDGET);
        // Halt and stall take priority over the budget.
        if (halt_req || stall_hit) begin
          state_d   = S_DRAIN;
          halted_d  = 1'b1;
          timeout_d = 1'b0;
          drain_d   = '0;
        end else if (budget_hit) begin
          state_d   = S_DRAIN;
          timeout_d = 1'b1;
          drain_d   = '0;
        end
      end
      S_DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          state_d = S_DONE;
        end else begin
          drain_d = drain_q + DRAIN_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    complete_d = (state_d == S_DRAIN);
    finish_d   = (state_d == S_DONE);
  end

  // State and output registers, cleared asynchronously by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cycles_q   <= '0;
      timeout_q  <= 1'b0;
      halted_q   <= 1'b0;
      complete_q <= 1'b0;
      finish_q   <= 1'b0;
      stall_q    <= '0;
      last_pc_q  <= '0;
      have_pc_q  <= 1'b0;
      drain_q    <= '0;
    end else begin
      state_q    <= state_d;
      cycles_q   <= cycles_d;
      timeout_q  <= timeout_d;
      halted_q   <= halted_d;
      complete_q <= complete_d;
      finish_q   <= finish_d;
      stall_q    <= stall_d;
      last_pc_q  <= last_pc_d;
      have_pc_q  <= have_pc_d;
      drain_q    <= drain_d;
    end
  end

  assign state    = state_q;
  assign cycles   = cycles_q;
  assign timeout  = timeout_q;
  assign halted   = halted_q;
  assign complete = complete_q;
  assign finish   = finish_q;

endmodule

// File: tb/tb_run_controller.sv
// Scoreboard bench for run_controller: stimulus queues expected run results,
// a negedge monitor compares them when finish rises.
module tb_run_controller;

  localparam int unsigned CNT_W = 32;
  localparam int unsigned PC_W  = 32;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic             halt_req = 1'b0;
  logic [PC_W-1:0]  pc = '0;
  logic             pc_valid = 1'b0;
  logic             complete;
  logic             finish;
  logic [1:0]       state;
  logic [CNT_W-1:0] cycles;
  logic             timeout;
  logic             halted;

  typedef struct {
    int unsigned cyc;
    logic        tmo;
    logic        hlt;
    int unsigned drain;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   stim_to = 0;
  logic expect_idle = 1'b0;
  logic stim_done = 1'b0;

  run_controller #(
    .CNT_W(CNT_W), .RUNTIME(100), .DRAIN(1), .PC_W(PC_W), .IDLE_LIMIT(8)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .halt_req(halt_req),
    .pc(pc), .pc_valid(pc_valid), .complete(complete), .finish(finish),
    .state(state), .cycles(cycles), .timeout(timeout), .halted(halted)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, time %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_finish();
    int n = 0;
    while (!finish && n < 300) begin
      tick();
      n++;
    end
    if (!finish) stim_to++;
  endtask

  // Budget run with pc incrementing; start re-pulsed at RUN cycle 30.
  task automatic run_budget();
    exp_q.push_back('{99, 1'b1, 1'b0, 1});
    pulse_start();
    for (int k = 1; k < 300 && !finish; k++) begin
      pc       = PC_W'(k);
      pc_valid = 1'b1;
      start    = (k == 30);
      tick();
    end
    start    = 1'b0;
    pc_valid = 1'b0;
    wait_finish();
  endtask

  // Stimulus.
  initial begin
    tick();
    tick();
    reset = 1'b0;
    expect_idle = 1'b1;
    repeat (5) tick();
    expect_idle = 1'b0;

    run_budget();
    repeat (3) tick();
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;

    // Halt at RUN cycle 20, restarted from DONE.
    exp_q.push_back('{20, 1'b0, 1'b1, 1});
    pulse_start();
    for (int k = 1; k <= 20; k++) begin
      halt_req = (k == 20);
      tick();
    end
    halt_req = 1'b0;
    wait_finish();
    tick();

    // Stall: constant valid pc, reference at cycle 1, 8 repeats end at cycle 9.
    exp_q.push_back('{9, 1'b0, 1'b1, 1});
    pulse_start();
    pc = 32'h100;
    for (int k = 1; k < 300 && !finish; k++) begin
      pc_valid = 1'b1;
      tick();
    end
    pc_valid = 1'b0;
    wait_finish();
    tick();

    // Stall with pc_valid on odd cycles only: ninth valid cycle is 17.
    exp_q.push_back('{17, 1'b0, 1'b1, 1});
    pulse_start();
    for (int k = 1; k < 300 && !finish; k++) begin
      pc_valid = (k % 2 == 1);
      tick();
    end
    pc_valid = 1'b0;
    wait_finish();
    tick();

    // Halt on the same cycle the budget is reached.
    exp_q.push_back('{99, 1'b0, 1'b1, 1});
    pulse_start();
    for (int k = 1; k <= 99; k++) begin
      pc       = PC_W'(k + 1000);
      pc_valid = 1'b1;
      halt_req = (k == 99);
      tick();
    end
    halt_req = 1'b0;
    pc_valid = 1'b0;
    wait_finish();
    tick();

    // Reset between edges during RUN cycle 50; no restart without start.
    pulse_start();
    repeat (49) tick();
    #2;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    expect_idle = 1'b1;
    repeat (20) tick();
    expect_idle = 1'b0;

    run_budget();
    repeat (3) tick();
    stim_done = 1'b1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (time %0t)", name, act, req, $time);
    end
  endtask

  // Monitor and scoreboard.
  initial begin
    logic [1:0]  prev_state = 2'd0;
    logic        prev_finish = 1'b0;
    logic        reset_seen = 1'b0;
    int unsigned drain_cnt = 0;
    int unsigned bad_complete = 0;
    exp_t e;
    while (!stim_done) begin
      @(negedge clk);
      if (reset && !reset_seen) begin
        chk("reset_state", 64'(state), 64'd0);
        chk("reset_cycles", 64'(cycles), 64'd0);
        chk("reset_flags", 64'({complete, finish, timeout, halted}), 64'd0);
      end
      reset_seen = reset;
      if (reset) begin
        prev_state  = 2'd0;
        prev_finish = 1'b0;
      end else begin
        if (expect_idle) chk("idle_hold", 64'({state, finish, complete}), 64'd0);
        if (state == 2'd1 && prev_state != 2'd1) begin
          chk("run_entry_cycles", 64'(cycles), 64'd0);
          chk("run_entry_flags", 64'({timeout, halted}), 64'd0);
          drain_cnt    = 0;
          bad_complete = 0;
        end
        if (complete) drain_cnt++;
        if (complete != (state == 2'd2)) bad_complete++;
        if (finish && !prev_finish) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_finish", 64'd1, 64'd0);
          end else begin
            e = exp_q.pop_front();
            chk("done_state", 64'(state), 64'd3);
            chk("run_cycles", 64'(cycles), 64'(e.cyc));
            chk("run_timeout", 64'(timeout), 64'(e.tmo));
            chk("run_halted", 64'(halted), 64'(e.hlt));
            chk("drain_len", 64'(drain_cnt), 64'(e.drain));
            chk("complete_only_in_drain", 64'(bad_complete), 64'd0);
          end
        end
        prev_state  = state;
        prev_finish = finish;
      end
    end
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    chk("stim_timeouts", 64'(stim_to), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/run_controller.md
RUN_CONTROLLER -- requirements
Module: run_controller

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of the cycle counter.
REQ-002 SHALL have parameter RUNTIME, default 100, cycle budget per run; legal range DRAIN+1 .. 2^CNT_W-1.
REQ-003 SHALL have parameter DRAIN, default 1, number of cycles `complete` is held before `finish`; legal range 1..255.
REQ-004 SHALL have parameter PC_W, default 32, width of the monitored program counter.
REQ-005 SHALL have parameter IDLE_LIMIT, default 8, consecutive repeated-PC cycles that count as a stall; 0 disables stall detection.
REQ-006 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-007 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-008 SHALL have port start  input  1  one-cycle request to begin a run.
REQ-009 SHALL have port halt_req  input  1  processor-signalled halt.
REQ-010 SHALL have port pc  input  PC_W  processor program counter.
REQ-011 SHALL have port pc_valid  input  1  qualifies pc this cycle.
REQ-012 SHALL have port complete  output  1  drain-window indication to the processor.
REQ-013 SHALL have port finish  output  1  run ended.
REQ-014 SHALL have port state  output  2  IDLE=0, RUN=1, DRAIN=2, DONE=3.
REQ-015 SHALL have port cycles  output  CNT_W  cycles spent in RUN in the current or last run.
REQ-016 SHALL have port timeout  output  1  last run ended by budget.
REQ-017 SHALL have port halted  output  1  last run ended by halt_req or stall.

Function
REQ-018 SHALL implement states IDLE, RUN, DRAIN, DONE, with all outputs registered.
REQ-019 SHALL, in IDLE with start=1, enter RUN next cycle and clear cycles, timeout, halted and the stall counter.
REQ-020 SHALL increment cycles by 1 on every cycle spent in RUN, saturating at 2^CNT_W-1.
REQ-021 SHALL leave RUN for DRAIN when halt_req=1, when the stall counter reaches IDLE_LIMIT (IDLE_LIMIT>0), or when cycles reaches RUNTIME-DRAIN.
REQ-022 SHALL, when a halt_req or stall exit occurs, set halted=1 and timeout=0 on the transition.
REQ-023 SHALL, when the budget is the only exit cause, set timeout=1 on the transition.
REQ-024 SHALL give halt and stall priority over the budget when exit causes coincide (halted=1, timeout=0).
REQ-025 SHALL, in the stall detector, increment the stall counter on each pc_valid=1 cycle whose pc equals the last valid pc.
REQ-026 SHALL reset the stall counter to 0 on a pc_valid=1 cycle with a differing pc, and on the first valid pc after entering RUN.
REQ-027 SHALL hold the stall counter on pc_valid=0 cycles.
REQ-028 SHALL drive complete=1 in every DRAIN cycle only.
REQ-029 SHALL stay in DRAIN exactly DRAIN cycles, then enter DONE.
REQ-030 SHALL drive finish=1 in DONE, held until start or reset.
REQ-031 SHALL, in DONE with start=1, re-enter RUN with the same clearing as REQ-019.
REQ-032 SHALL ignore start in RUN and DRAIN.
REQ-033 SHALL ignore halt_req outside RUN.
REQ-034 SHALL freeze cycles, timeout and halted outside RUN until the next start.

Reset
REQ-035 SHALL, on reset=1 at any time including mid-run, immediately force state=IDLE and cycles=0.
REQ-036 SHALL, on reset=1, immediately force complete=finish=timeout=halted=0 and clear the stall and drain counters, without waiting for clk.
REQ-037 SHALL, after reset deassertion, remain in IDLE until start=1.

Verification
REQ-038 SHALL be verified for budget exit: defaults, start pulse, pc incrementing -> complete=1 for 1 cycle with cycles=99, then finish=1, timeout=1, halted=0.
REQ-039 SHALL be verified for halt exit: halt_req pulse at RUN cycle 20 -> DRAIN next cycle, halted=1, timeout=0, cycles=20 frozen, finish after DRAIN.
REQ-040 SHALL be verified for stall exit: IDLE_LIMIT=8, pc held constant with pc_valid=1 -> DRAIN after 8 repeats, halted=1; with pc_valid toggling 0/1, the exit takes proportionally longer (counter holds).
REQ-041 SHALL be verified for coincident exit: halt_req on the same cycle cycles hits RUNTIME-DRAIN -> halted=1, timeout=0.
REQ-042 SHALL be verified for reset mid-run: reset asserted at RUN cycle 50 between clock edges -> state=0 and all outputs 0 before the next edge; no restart without start.
REQ-043 SHALL be verified for restart: start in DONE -> RUN with cycles=0 and flags cleared; start pulsed during RUN -> no effect on cycles.
